// File: rtl/button_pkg.sv
// Shared button indices and timing constants for the push-button conditioning path.
package button_pkg;

  localparam int BTN_A       = 0;
  localparam int BTN_B       = 1;
  localparam int BTN_UP      = 2;
  localparam int BTN_DOWN    = 3;
  localparam int BTN_LEFT    = 4;
  localparam int BTN_RIGHT   = 5;
  localparam int BTN_START   = 6;
  localparam int NUM_BUTTONS = 7;

  // 50 MHz board timing: 10 ms debounce, 0.5 s first repeat, 0.1 s repeat period.
  localparam int DEBOUNCE_CYCLES_50M = 500000;
  localparam int REPEAT_DELAY_50M    = 25000000;
  localparam int REPEAT_PERIOD_50M   = 5000000;

  localparam int DEBOUNCE_CYCLES_SIM = 4;
  localparam int REPEAT_DELAY_SIM    = 10;
  localparam int REPEAT_PERIOD_SIM   = 3;

  localparam logic [NUM_BUTTONS-1:0] REPEAT_MASK_DEFAULT = 7'b0111100;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button: 2-FF sync, debounce, press pulse and optional auto-repeat.
// Pulse appears DEBOUNCE_CYCLES+2 edges after raw rises; no backpressure, pulses are fire-and-forget.
module button_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50M,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_50M,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_50M,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic held,
  output logic pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = max_int($clog2(REPEAT_DELAY + 1), $clog2(REPEAT_PERIOD + 1));
  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES);
  localparam logic [HW-1:0] DELAY_LAST  = HW'(REPEAT_DELAY);
  localparam logic [HW-1:0] PERIOD_LAST = HW'(REPEAT_PERIOD);

  logic          s1_q, s2_q;
  logic          stable_q, stable_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d, db_inc;
  logic [HW-1:0] hold_q, hold_d, hold_inc;
  logic          phase_q, phase_d;
  logic          pulse_q, pulse_d;

  always_comb begin
    stable_d = stable_q;
    db_cnt_d = '0;
    db_inc   = db_cnt_q + 1'b1;
    if (s2_q != stable_q) begin
      if (db_inc == DB_LAST) begin
        stable_d = s2_q;
      end else begin
        db_cnt_d = db_inc;
      end
    end

    hold_d   = hold_q;
    phase_d  = phase_q;
    pulse_d  = 1'b0;
    hold_inc = hold_q + 1'b1;
    if (!stable_d) begin
      hold_d  = '0;
      phase_d = 1'b0;
    end else if (!stable_q) begin
      hold_d  = '0;
      phase_d = 1'b0;
      pulse_d = 1'b1;
    end else if (REPEAT_EN) begin
      // Counter reloads on every repeat, so it never exceeds the larger interval.
      if (hold_inc == (phase_q ? PERIOD_LAST : DELAY_LAST)) begin
        hold_d  = '0;
        phase_d = 1'b1;
        pulse_d = 1'b1;
      end else begin
        hold_d = hold_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      db_cnt_q <= '0;
      hold_q   <= '0;
      phase_q  <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      s1_q     <= raw;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      db_cnt_q <= db_cnt_d;
      hold_q   <= hold_d;
      phase_q  <= phase_d;
      pulse_q  <= pulse_d;
    end
  end

  assign held  = stable_q;
  assign pulse = pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the seven board buttons into single-cycle press/repeat pulses for the game top level.
// Pulse latency DEBOUNCE_CYCLES+2 edges from raw; no backpressure, any_press is the same-cycle OR.
module button_conditioner
  import button_pkg::*;
#(
  parameter int                     DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50M,
  parameter int                     REPEAT_DELAY    = REPEAT_DELAY_50M,
  parameter int                     REPEAT_PERIOD   = REPEAT_PERIOD_50M,
  parameter logic [NUM_BUTTONS-1:0] REPEAT_MASK     = REPEAT_MASK_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   a_raw,
  input  logic                   b_raw,
  input  logic                   up_raw,
  input  logic                   down_raw,
  input  logic                   left_raw,
  input  logic                   right_raw,
  input  logic                   start_raw,
  output logic                   a_button,
  output logic                   b_button,
  output logic                   up_button,
  output logic                   down_button,
  output logic                   left_button,
  output logic                   right_button,
  output logic                   start_button,
  output logic [NUM_BUTTONS-1:0] held,
  output logic                   any_press
);

  logic [NUM_BUTTONS-1:0] raw_vec;
  logic [NUM_BUTTONS-1:0] pulse_vec;

  always_comb begin
    raw_vec            = '0;
    raw_vec[BTN_A]     = a_raw;
    raw_vec[BTN_B]     = b_raw;
    raw_vec[BTN_UP]    = up_raw;
    raw_vec[BTN_DOWN]  = down_raw;
    raw_vec[BTN_LEFT]  = left_raw;
    raw_vec[BTN_RIGHT] = right_raw;
    raw_vec[BTN_START] = start_raw;
  end

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .REPEAT_EN      (REPEAT_MASK[i])
    ) u_chan (
      .clk  (clk),
      .reset(reset),
      .raw  (raw_vec[i]),
      .held (held[i]),
      .pulse(pulse_vec[i])
    );
  end

  assign a_button     = pulse_vec[BTN_A];
  assign b_button     = pulse_vec[BTN_B];
  assign up_button    = pulse_vec[BTN_UP];
  assign down_button  = pulse_vec[BTN_DOWN];
  assign left_button  = pulse_vec[BTN_LEFT];
  assign right_button = pulse_vec[BTN_RIGHT];
  assign start_button = pulse_vec[BTN_START];
  assign any_press    = |pulse_vec;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with fast timing (debounce 4, delay 10, period 3).
module tb_button_conditioner;
  import button_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a_raw = 1'b0, b_raw = 1'b0, up_raw = 1'b0, down_raw = 1'b0;
  logic       left_raw = 1'b0, right_raw = 1'b0, start_raw = 1'b0;
  logic       a_button, b_button, up_button, down_button;
  logic       left_button, right_button, start_button;
  logic [6:0] held;
  logic       any_press;
  logic [6:0] pv;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES_SIM),
    .REPEAT_DELAY   (REPEAT_DELAY_SIM),
    .REPEAT_PERIOD  (REPEAT_PERIOD_SIM),
    .REPEAT_MASK    (7'b0111100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .a_raw       (a_raw),
    .b_raw       (b_raw),
    .up_raw      (up_raw),
    .down_raw    (down_raw),
    .left_raw    (left_raw),
    .right_raw   (right_raw),
    .start_raw   (start_raw),
    .a_button    (a_button),
    .b_button    (b_button),
    .up_button   (up_button),
    .down_button (down_button),
    .left_button (left_button),
    .right_button(right_button),
    .start_button(start_button),
    .held        (held),
    .any_press   (any_press)
  );

  assign pv = {start_button, right_button, left_button, down_button, up_button, b_button, a_button};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_raw(input logic [6:0] v);
    {start_raw, right_raw, left_raw, down_raw, up_raw, b_raw, a_raw} = v;
  endtask

  task automatic chk_cycle(input string tag, input logic [6:0] exp_pulse, input logic [6:0] exp_held);
    chk({tag, "_pulse"}, 32'(pv), 32'(exp_pulse));
    chk({tag, "_held"}, 32'(held), 32'(exp_held));
    chk({tag, "_any"}, 32'(any_press), 32'(|exp_pulse));
  endtask

  task automatic do_reset();
    set_raw(7'b0);
    reset = 1'b1;
    step();
    step();
    chk_cycle("reset", 7'b0, 7'b0);
    reset = 1'b0;
  endtask

  initial begin
    logic [6:0] ep, eh;
    bit         rp;

    // Single non-repeating press: one pulse after edge 5, never again.
    do_reset();
    for (int k = 0; k < 40; k++) begin
      set_raw(7'b0000001);
      step();
      ep = (k == 5) ? 7'b0000001 : 7'b0;
      eh = (k >= 5) ? 7'b0000001 : 7'b0;
      chk_cycle("a_press", ep, eh);
    end

    // Auto-repeat on up, released before edge 30.
    do_reset();
    for (int k = 0; k < 46; k++) begin
      set_raw((k < 30) ? 7'b0000100 : 7'b0);
      step();
      rp = (k == 5) || (k >= 15 && k <= 33 && ((k - 15) % 3 == 0));
      ep = rp ? 7'b0000100 : 7'b0;
      eh = (k >= 5 && k < 35) ? 7'b0000100 : 7'b0;
      chk_cycle("up_repeat", ep, eh);
    end

    // Bouncing right: 3 high, 1 low, 2 high, low, then steady high from edge 10.
    do_reset();
    for (int k = 0; k < 25; k++) begin
      set_raw((k <= 2 || k == 4 || k == 5 || k >= 10) ? 7'b0100000 : 7'b0);
      step();
      ep = (k == 15) ? 7'b0100000 : 7'b0;
      eh = (k >= 15) ? 7'b0100000 : 7'b0;
      chk_cycle("right_bounce", ep, eh);
    end

    // Reset for one cycle while down repeats; re-qualifies from scratch.
    do_reset();
    for (int k = 0; k < 46; k++) begin
      set_raw(7'b0001000);
      reset = (k == 22);
      step();
      rp = (k == 5) || (k == 15) || (k == 18) || (k == 21) || (k == 28) ||
           (k >= 38 && ((k - 38) % 3 == 0));
      ep = rp ? 7'b0001000 : 7'b0;
      eh = ((k >= 5 && k < 22) || k >= 28) ? 7'b0001000 : 7'b0;
      chk_cycle("down_reset", ep, eh);
    end
    reset = 1'b0;

    // a and start together: simultaneous single pulses.
    do_reset();
    for (int k = 0; k < 13; k++) begin
      set_raw(7'b1000001);
      step();
      ep = (k == 5) ? 7'b1000001 : 7'b0;
      eh = (k >= 5) ? 7'b1000001 : 7'b0;
      chk_cycle("a_start", ep, eh);
    end

    // Idle for 100 cycles.
    do_reset();
    for (int k = 0; k < 100; k++) begin
      set_raw(7'b0);
      step();
      chk_cycle("idle", 7'b0, 7'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
